// File: rtl/spi_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_arbiter_if
// Request/response and SPI-master command bundle for spi_arbiter.
//   slave  : arbiter view (takes requests, drives the SPI master command)
//   master : environment view (requesters plus SPI master)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
);
  // requester side
  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_rw;
  logic [2*NUM_REQ-1:0]          i_req_mode;
  logic [15:0]                   i_timeout;
  logic [NUM_REQ-1:0]            o_ack;
  logic                          o_err;
  logic [DATA_WIDTH-1:0]         o_rdata;
  // SPI master side
  logic                          o_spi_enable;
  logic [ADDR_WIDTH-1:0]         o_spi_addr;
  logic [DATA_WIDTH-1:0]         o_spi_data;
  logic                          o_spi_rw;
  logic                          o_spi_cpol;
  logic                          o_spi_cpha;
  logic                          i_spi_busy;
  logic [15:0]                   i_spi_read_word;

  modport slave (
    input  i_req, i_req_addr, i_req_data, i_req_rw, i_req_mode, i_timeout,
    input  i_spi_busy, i_spi_read_word,
    output o_ack, o_err, o_rdata,
    output o_spi_enable, o_spi_addr, o_spi_data, o_spi_rw, o_spi_cpol, o_spi_cpha
  );

  modport master (
    output i_req, i_req_addr, i_req_data, i_req_rw, i_req_mode, i_timeout,
    output i_spi_busy, i_spi_read_word,
    input  o_ack, o_err, o_rdata,
    input  o_spi_enable, o_spi_addr, o_spi_data, o_spi_rw, o_spi_cpol, o_spi_cpha
  );
endinterface

`default_nettype wire

// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Optional watchdog enabled by defining SPI_ARBITER_TIMEOUT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  wire logic     i_clk,
  input  wire logic     i_rst,
  spi_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef SPI_ARBITER_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RESPOND   = 3'd3,
    S_RECOVER   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RESPOND   = 3'd3
  } state_t;
`endif

  state_t                state;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      grant;
  logic [PTR_W-1:0]      next_grant;
  logic                  grant_found;
  logic [NUM_REQ-1:0]    grant_onehot;

  logic [NUM_REQ-1:0]    ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  spi_enable;
  logic [ADDR_WIDTH-1:0] spi_addr;
  logic [DATA_WIDTH-1:0] spi_data;
  logic                  spi_rw;
  logic                  spi_cpol;
  logic                  spi_cpha;

`ifdef SPI_ARBITER_TIMEOUT_EN
  logic [15:0]           wd;
  logic                  err;
  logic                  timeout_hit;
  assign timeout_hit = (bus.i_timeout != 16'd0) && (wd == bus.i_timeout);
`endif

  // Round-robin search: first set request strictly after the last grant,
  // wrapping around so the previous winner is considered last.
  always_comb begin
    int idx;
    next_grant  = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!grant_found && bus.i_req[idx]) begin
        grant_found = 1'b1;
        next_grant  = idx[PTR_W-1:0];
      end
    end
  end

  assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;

  // Arbitration FSM; all outputs are registered here. The ack pulse is raised
  // on entry to S_RESPOND so it is visible for exactly the S_RESPOND cycle,
  // which gives the requester time to drop its request before S_IDLE samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      ptr        <= PTR_W'(NUM_REQ - 1);
      grant      <= '0;
      ack        <= '0;
      rdata      <= '0;
      spi_enable <= 1'b0;
      spi_addr   <= '0;
      spi_data   <= '0;
      spi_rw     <= 1'b0;
      spi_cpol   <= 1'b0;
      spi_cpha   <= 1'b0;
`ifdef SPI_ARBITER_TIMEOUT_EN
      wd         <= 16'd0;
      err        <= 1'b0;
`endif
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (grant_found && !bus.i_spi_busy) begin
            grant      <= next_grant;
            spi_addr   <= bus.i_req_addr[int'(next_grant)*ADDR_WIDTH +: ADDR_WIDTH];
            spi_data   <= bus.i_req_data[int'(next_grant)*DATA_WIDTH +: DATA_WIDTH];
            spi_rw     <= bus.i_req_rw[next_grant];
            spi_cpol   <= bus.i_req_mode[2*int'(next_grant) + 1];
            spi_cpha   <= bus.i_req_mode[2*int'(next_grant)];
            spi_enable <= 1'b1;
`ifdef SPI_ARBITER_TIMEOUT_EN
            wd         <= 16'd0;
`endif
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
`ifdef SPI_ARBITER_TIMEOUT_EN
          wd <= wd + 16'd1;
          if (timeout_hit) begin
            spi_enable <= 1'b0;
            state      <= S_RECOVER;
          end else
`endif
          if (bus.i_spi_busy) begin
            spi_enable <= 1'b0;
            state      <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
`ifdef SPI_ARBITER_TIMEOUT_EN
          wd <= wd + 16'd1;
          if (timeout_hit) begin
            state <= S_RECOVER;
          end else
`endif
          if (!bus.i_spi_busy) begin
            rdata <= bus.i_spi_read_word[DATA_WIDTH-1:0];
            ack   <= grant_onehot;
            state <= S_RESPOND;
          end
        end

        S_RESPOND: begin
          ptr   <= grant;
`ifdef SPI_ARBITER_TIMEOUT_EN
          err   <= 1'b0;
`endif
          state <= S_IDLE;
        end

`ifdef SPI_ARBITER_TIMEOUT_EN
        // Wait for the SPI master to go idle, then report the abandoned
        // transaction as an error with zeroed read data.
        S_RECOVER: begin
          if (!bus.i_spi_busy) begin
            rdata <= '0;
            err   <= 1'b1;
            ack   <= grant_onehot;
            state <= S_RESPOND;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ack        = ack;
  assign bus.o_rdata      = rdata;
  assign bus.o_spi_enable = spi_enable;
  assign bus.o_spi_addr   = spi_addr;
  assign bus.o_spi_data   = spi_data;
  assign bus.o_spi_rw     = spi_rw;
  assign bus.o_spi_cpol   = spi_cpol;
  assign bus.o_spi_cpha   = spi_cpha;
`ifdef SPI_ARBITER_TIMEOUT_EN
  assign bus.o_err        = err;
`else
  assign bus.o_err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal 2..8.
REQ-002 Parameter DATA_WIDTH, default 16: data bits per transaction, legal 1..16.
REQ-003 Parameter ADDR_WIDTH, default 15: address bits per transaction.
REQ-004 i_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_req  in  NUM_REQ  per-requester request level.
REQ-007 i_req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester n at slice n.
REQ-008 i_req_data  in  NUM_REQ*DATA_WIDTH  flattened write data.
REQ-009 i_req_rw  in  NUM_REQ  1 = read, 0 = write.
REQ-010 i_req_mode  in  2*NUM_REQ  per requester {cpol,cpha}.
REQ-011 i_timeout  in  16  watchdog limit in i_clk cycles; 0 disables.
REQ-012 o_ack  out  NUM_REQ  one-hot one-cycle completion pulse.
REQ-013 o_err  out  1  timeout flag, valid with o_ack.
REQ-014 o_rdata  out  DATA_WIDTH  read data, valid with o_ack.
REQ-015 o_spi_enable  out  1  start request to the SPI master.
REQ-016 o_spi_addr / o_spi_data / o_spi_rw  out  ADDR_WIDTH / DATA_WIDTH / 1  granted command.
REQ-017 o_spi_cpol / o_spi_cpha  out  1 each  granted mode.
REQ-018 i_spi_busy / i_spi_read_word  in  1 / 16  SPI master busy and read word; master burst inputs tied low at integration.

Function
REQ-019 States: S_IDLE, S_ISSUE, S_WAIT_DONE, S_RESPOND, S_RECOVER (macro only).
REQ-020 S_IDLE: when any i_req set and i_spi_busy==0, grant first set requester searching upward from ptr+1 modulo NUM_REQ; go S_ISSUE; no grant while i_spi_busy==1.
REQ-021 At grant, latch granted slice into all o_spi_* registers and set o_spi_enable; o_spi_enable high the cycle after i_req sampled.
REQ-022 i_req_* changes after grant are ignored; o_spi_* hold last values outside S_ISSUE.
REQ-023 S_ISSUE: hold o_spi_enable=1 until i_spi_busy==1, then clear it, go S_WAIT_DONE.
REQ-024 S_WAIT_DONE: on i_spi_busy==0, o_rdata <= i_spi_read_word[DATA_WIDTH-1:0] (reads and writes alike), go S_RESPOND.
REQ-025 S_RESPOND: o_ack[grant]=1 for exactly one cycle, o_err=0, ptr <= grant, go S_IDLE.
REQ-026 Requester withdrawing i_req after grant: transaction completes, ack still issued.
REQ-027 Requester shall drop i_req the cycle after o_ack; the one S_IDLE-to-grant cycle gap guarantees no double grant.
REQ-028 Fairness: continuously requesting requester waits at most NUM_REQ-1 transactions.

Reset
REQ-029 On i_rst: state S_IDLE, ptr NUM_REQ-1 (requester 0 wins first), all outputs 0, watchdog 0.
REQ-030 Reset mid-transaction abandons it without ack; SPI master shares i_rst.

Configuration
REQ-031 Macro SPI_ARBITER_TIMEOUT_EN defined: 16-bit watchdog cleared on entry to S_ISSUE, counts in S_ISSUE/S_WAIT_DONE; on count==i_timeout with i_timeout!=0, clear o_spi_enable, go S_RECOVER; S_RECOVER waits i_spi_busy==0, then S_RESPOND with o_err=1, o_rdata=0.
REQ-032 Macro undefined: no watchdog, no S_RECOVER, i_timeout ignored, o_err constant 0.

Verification
REQ-033 Single read, req1, rw=1, addr 0x1234, model returns 0xBEEF -> o_ack=0010, o_rdata=0xBEEF, o_spi_addr=0x1234.
REQ-034 All four request simultaneously after reset -> grants 0,1,2,3, then 0; no back-to-back double ack.
REQ-035 req2 mode {1,0}, write data 0xA5A5; i_req_data changed mid-transfer -> o_spi_cpol=1, o_spi_cpha=0, o_spi_data stays 0xA5A5.
REQ-036 Macro on, i_timeout=50, busy never rises -> enable drops after 50 cycles, o_ack pulse with o_err=1, o_rdata=0.
REQ-037 i_rst asserted during S_WAIT_DONE -> outputs 0 immediately, no ack; next request served from requester 0.
